dbus_ctrl: RTL and testbench

//   Memory-stage data-bus controller, directly upstream of the load-extraction stage.

---
 rtl/dbus_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dbus_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_ctrl.sv
// rtl/dbus_ctrl.sv - memory-stage data-bus controller: alignment check, store lane
// steering, request/response handshake with pipeline stall, raw word return.

package common;
  typedef logic [31:0] word_t;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_t;
endpackage

module dbus_ctrl
  import common::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  mem_t        req_type,
  input  word_t       req_addr,
  input  word_t       req_wdata,
  input  logic        hold,
  output logic        stall,
  output logic        adel,
  output logic        ades,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output word_t       dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output word_t       dreq_wdata,
  input  logic        dresp_valid,
  input  word_t       dresp_data,
  output logic        resp_valid,
  output word_t       rd_raw,
  output logic [1:0]  rd_addr,
  output mem_t        rd_type
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  mem_t        lat_type;
  logic        lat_store;

  logic        is_load;
  logic        is_store;
  logic        misalign;
  logic        accept;
  logic [1:0]  nxt_size;
  logic [3:0]  nxt_strobe;
  word_t       nxt_wdata;

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misalign   = 1'b0;
    nxt_size   = 2'd0;
    nxt_strobe = 4'b0000;
    nxt_wdata  = '0;
    case (req_type)
      MEM_LB, MEM_LBU: begin
        is_load  = 1'b1;
        nxt_size = 2'd0;
      end
      MEM_LH, MEM_LHU: begin
        is_load  = 1'b1;
        nxt_size = 2'd1;
        misalign = req_addr[0];
      end
      MEM_LW: begin
        is_load  = 1'b1;
        nxt_size = 2'd2;
        misalign = |req_addr[1:0];
      end
      MEM_SB: begin
        is_store   = 1'b1;
        nxt_size   = 2'd0;
        nxt_strobe = 4'b0001 << req_addr[1:0];
        nxt_wdata  = {4{req_wdata[7:0]}};
      end
      MEM_SH: begin
        is_store   = 1'b1;
        nxt_size   = 2'd1;
        misalign   = req_addr[0];
        nxt_strobe = req_addr[1] ? 4'b1100 : 4'b0011;
        nxt_wdata  = {2{req_wdata[15:0]}};
      end
      MEM_SW: begin
        is_store   = 1'b1;
        nxt_size   = 2'd2;
        misalign   = |req_addr[1:0];
        nxt_strobe = 4'b1111;
        nxt_wdata  = req_wdata;
      end
      default: ;
    endcase
  end

  // Alignment faults and acceptance are only meaningful while no access is in flight.
  assign adel   = (state == S_IDLE) && req_valid && is_load  && misalign;
  assign ades   = (state == S_IDLE) && req_valid && is_store && misalign;
  assign accept = (state == S_IDLE) && req_valid && (is_load || is_store) && !misalign;
  assign stall  = accept || (state == S_REQ) || (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lat_type    <= MEM_NONE;
      lat_store   <= 1'b0;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= 2'd0;
      dreq_strobe <= 4'b0000;
      dreq_wdata  <= '0;
      resp_valid  <= 1'b0;
      rd_raw      <= '0;
      rd_addr     <= 2'd0;
      rd_type     <= MEM_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_type    <= req_type;
            lat_store   <= is_store;
            dreq_valid  <= 1'b1;
            dreq_addr   <= req_addr;
            dreq_size   <= nxt_size;
            dreq_strobe <= nxt_strobe;
            dreq_wdata  <= nxt_wdata;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (dreq_ready) begin
            dreq_valid <= 1'b0;
            if (dresp_valid) begin
              resp_valid <= 1'b1;
              rd_raw     <= lat_store ? '0 : dresp_data;
              rd_addr    <= dreq_addr[1:0];
              rd_type    <= lat_type;
              state      <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dresp_valid) begin
            resp_valid <= 1'b1;
            rd_raw     <= lat_store ? '0 : dresp_data;
            rd_addr    <= dreq_addr[1:0];
            rd_type    <= lat_type;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          // rd_* stay valid after leaving DONE; only resp_valid marks a fresh result.
          if (!hold) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb/tb_dbus_ctrl.sv - randomized and directed bench for dbus_ctrl against a byte-lane
// reference model.

module tb_dbus_ctrl;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  mem_t        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        hold;
  logic        stall;
  logic        adel;
  logic        ades;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic        resp_valid;
  logic [31:0] rd_raw;
  logic [1:0]  rd_addr;
  mem_t        rd_type;

  int total = 0;
  int bad   = 0;

  dbus_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .hold(hold), .stall(stall),
    .adel(adel), .ades(ades), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
    .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
    .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .resp_valid(resp_valid), .rd_raw(rd_raw), .rd_addr(rd_addr), .rd_type(rd_type)
  );

  always #5 clk = ~clk;

  // Reference model: an access covers n consecutive byte lanes starting at addr[1:0].
  function automatic int nbytes(input mem_t t);
    case (t)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit is_st(input mem_t t);
    return (t == MEM_SB) || (t == MEM_SH) || (t == MEM_SW);
  endfunction

  function automatic logic [1:0] m_size(input mem_t t);
    return (nbytes(t) == 1) ? 2'd0 : (nbytes(t) == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] m_strobe(input mem_t t, input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    int off = int'(a[1:0]);
    if (is_st(t))
      for (int i = 0; i < 4; i++)
        if (i >= off && i < off + nbytes(t)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input mem_t t, input logic [31:0] w);
    logic [31:0] r = '0;
    if (is_st(t))
      for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(t)) +: 8];
    return r;
  endfunction

  // Observations gathered by do_access for the test tasks to judge.
  int          o_stall_cycles, o_latency;
  bit          o_timeout, o_stable, o_reissue, o_frozen, o_idle_after, o_adel, o_ades;
  logic [1:0]  o_size, o_rd_addr;
  logic [3:0]  o_strobe;
  logic [31:0] o_wdata, o_addr, o_raw;
  mem_t        o_rd_type;

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; req_wdata = '0;
    hold = 1'b0; dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_access(input mem_t t, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] d, input int rlat, input int rdly,
                           input int hcyc, input bit stray);
    int rc = 0;
    int wc = 0;
    bit acc = 1'b0;
    bit seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = w;
    dreq_ready = 1'b0; dresp_valid = 1'b0; hold = 1'b0;
    #1;
    o_stall_cycles = stall ? 1 : 0; o_adel = adel; o_ades = ades;
    o_latency = -1; o_timeout = 1'b1; o_stable = 1'b1; o_reissue = dreq_valid;
    o_frozen = 1'b1; o_idle_after = 1'b0;
    for (int k = 1; k < 200; k++) begin
      @(negedge clk);
      dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = $urandom;
      if (resp_valid) begin
        o_latency = k; o_timeout = 1'b0;
        o_raw = rd_raw; o_rd_addr = rd_addr; o_rd_type = rd_type;
        hold = (hcyc > 0);
        #1;
        if (stall) o_stall_cycles++;
        break;
      end
      if (dreq_valid) begin
        if (!seen) begin
          seen = 1'b1;
          o_size = dreq_size; o_strobe = dreq_strobe; o_wdata = dreq_wdata; o_addr = dreq_addr;
        end else if (o_size !== dreq_size || o_strobe !== dreq_strobe ||
                     o_wdata !== dreq_wdata || o_addr !== dreq_addr) begin
          o_stable = 1'b0;
        end
        if (rc < rlat) begin
          rc++;
          if (stray) dresp_valid = 1'b1;
        end else begin
          dreq_ready = 1'b1; acc = 1'b1;
          if (rdly == 0) begin dresp_valid = 1'b1; dresp_data = d; end
        end
      end else if (acc) begin
        wc++;
        if (wc == rdly) begin dresp_valid = 1'b1; dresp_data = d; end
      end
      #1;
      if (stall) o_stall_cycles++;
    end
    if (o_timeout) begin
      apply_reset();
      return;
    end
    for (int h = 0; h < hcyc; h++) begin
      @(negedge clk);
      if (!resp_valid || rd_raw !== o_raw || rd_addr !== o_rd_addr || rd_type !== o_rd_type)
        o_frozen = 1'b0;
      #1;
      if (dreq_valid || stall) o_reissue = 1'b1;
    end
    hold = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    o_idle_after = !resp_valid && !dreq_valid && !stall;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (stall !== 1'b0)       begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (dreq_valid !== 1'b0)  begin bad++; $display("FAIL reset_dreq_valid got=%b want=0", dreq_valid); end
    total++; if (resp_valid !== 1'b0)  begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (rd_raw !== 32'h0 || rd_addr !== 2'b00 || dreq_strobe !== 4'b0000 ||
                 dreq_addr !== 32'h0 || dreq_wdata !== 32'h0)
      begin bad++; $display("FAIL reset_regs rd_raw=%h rd_addr=%b strobe=%b want all 0", rd_raw, rd_addr, dreq_strobe); end
    total++; if (rd_type !== MEM_NONE) begin bad++; $display("FAIL reset_rd_type got=%0d want=0", rd_type); end
  endtask

  task automatic test_load_min();
    do_access(MEM_LW, 32'h1000, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0);
    total++; if (o_latency !== 2)      begin bad++; $display("FAIL lw_latency got=%0d want=2", o_latency); end
    total++; if (o_stall_cycles !== 2) begin bad++; $display("FAIL lw_stall_cycles got=%0d want=2", o_stall_cycles); end
    total++; if (o_size !== 2'd2 || o_strobe !== 4'b0000 || o_wdata !== 32'h0 || o_addr !== 32'h1000)
      begin bad++; $display("FAIL lw_req size=%0d strobe=%b wdata=%h addr=%h want 2/0000/0/1000", o_size, o_strobe, o_wdata, o_addr); end
    total++; if (o_raw !== 32'hDEADBEEF || o_rd_addr !== 2'b00 || o_rd_type !== MEM_LW)
      begin bad++; $display("FAIL lw_rd raw=%h addr=%b type=%0d want deadbeef/00/%0d", o_raw, o_rd_addr, o_rd_type, MEM_LW); end
    total++; if (!o_idle_after)        begin bad++; $display("FAIL lw_idle_after got=0 want=1"); end
  endtask

  task automatic test_stores();
    do_access(MEM_SB, 32'h2003, 32'h000000A5, 32'hFFFFFFFF, 0, 1, 0, 1'b0);
    total++; if (o_strobe !== 4'b1000 || o_wdata !== 32'hA5A5A5A5 || o_size !== 2'd0)
      begin bad++; $display("FAIL sb_req strobe=%b wdata=%h size=%0d want 1000/a5a5a5a5/0", o_strobe, o_wdata, o_size); end
    total++; if (o_raw !== 32'h0 || o_rd_addr !== 2'b11)
      begin bad++; $display("FAIL sb_rd raw=%h addr=%b want 0/11", o_raw, o_rd_addr); end
    do_access(MEM_SH, 32'h2002, 32'h00001234, 32'hFFFFFFFF, 1, 0, 0, 1'b0);
    total++; if (o_strobe !== 4'b1100 || o_wdata !== 32'h12341234 || o_size !== 2'd1)
      begin bad++; $display("FAIL sh_req strobe=%b wdata=%h size=%0d want 1100/12341234/1", o_strobe, o_wdata, o_size); end
  endtask

  task automatic test_misalign();
    bit rose = 1'b0;
    bit bad_flags = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_type = MEM_SH; req_addr = 32'h2001; req_wdata = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (ades !== 1'b1 || adel !== 1'b0 || stall !== 1'b0) bad_flags = 1'b1;
      if (dreq_valid) rose = 1'b1;
      @(negedge clk);
    end
    total++; if (bad_flags) begin bad++; $display("FAIL sh_misalign flags ades=%b adel=%b stall=%b want 1/0/0", ades, adel, stall); end
    total++; if (rose)      begin bad++; $display("FAIL sh_misalign_dreq got=1 want=0"); end
    req_type = MEM_LW; req_addr = 32'h1002;
    #1;
    total++; if (adel !== 1'b1 || ades !== 1'b0 || stall !== 1'b0)
      begin bad++; $display("FAIL lw_misalign adel=%b ades=%b stall=%b want 1/0/0", adel, ades, stall); end
    req_type = MEM_NONE; req_addr = 32'h1003;
    @(negedge clk);
    #1;
    total++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || adel !== 1'b0 || ades !== 1'b0)
      begin bad++; $display("FAIL nonmem_ignored stall=%b dreq_valid=%b want 0/0", stall, dreq_valid); end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_access(MEM_LBU, 32'h3001, 32'h0, 32'h89ABCDEF, 3, 2, 0, 1'b1);
    total++; if (!o_stable) begin bad++; $display("FAIL lbu_stable got=0 want=1"); end
    total++; if (o_latency !== 7 || o_stall_cycles !== 7)
      begin bad++; $display("FAIL lbu_timing latency=%0d stall=%0d want 7/7", o_latency, o_stall_cycles); end
    total++; if (o_raw !== 32'h89ABCDEF || o_rd_addr !== 2'b01 || o_rd_type !== MEM_LBU || o_size !== 2'd0)
      begin bad++; $display("FAIL lbu_rd raw=%h addr=%b type=%0d size=%0d want 89abcdef/01/%0d/0", o_raw, o_rd_addr, o_rd_type, o_size, MEM_LBU); end
  endtask

  task automatic test_hold();
    do_access(MEM_LH, 32'h0000_5006, 32'h0, 32'h0BAD_F00D, 0, 0, 2, 1'b0);
    total++; if (!o_frozen)    begin bad++; $display("FAIL hold_frozen got=0 want=1"); end
    total++; if (o_reissue)    begin bad++; $display("FAIL hold_reissue got=1 want=0"); end
    total++; if (!o_idle_after) begin bad++; $display("FAIL hold_release_idle got=0 want=1"); end
  endtask

  task automatic test_reset_midaccess();
    @(negedge clk);
    req_valid = 1'b1; req_type = MEM_LW; req_addr = 32'h4000; dreq_ready = 1'b0; dresp_valid = 1'b0;
    @(negedge clk);
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    #1;
    total++; if (stall !== 1'b1 || dreq_valid !== 1'b0)
      begin bad++; $display("FAIL wait_state stall=%b dreq_valid=%b want 1/0", stall, dreq_valid); end
    reset = 1'b1; req_valid = 1'b0; dresp_valid = 1'b1; dresp_data = 32'hCAFEF00D;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || resp_valid !== 1'b0 ||
                 rd_raw !== 32'h0 || rd_type !== MEM_NONE || dreq_strobe !== 4'b0000)
      begin bad++; $display("FAIL midreset_outputs stall=%b dreq=%b resp=%b raw=%h type=%0d want all 0", stall, dreq_valid, resp_valid, rd_raw, rd_type); end
    @(negedge clk);
    dresp_valid = 1'b0;
    #1;
    total++; if (resp_valid !== 1'b0 || rd_raw !== 32'h0)
      begin bad++; $display("FAIL stray_resp resp_valid=%b raw=%h want 0/0", resp_valid, rd_raw); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  tv = 4'($urandom_range(1, 8));
      mem_t        t  = mem_t'(tv);
      logic [31:0] a  = $urandom;
      logic [31:0] w  = $urandom;
      logic [31:0] d  = $urandom;
      int rlat = $urandom_range(0, 3);
      int rdly = $urandom_range(0, 3);
      int hcyc = $urandom_range(0, 2);
      if (nbytes(t) == 2) a[0] = 1'b0;
      if (nbytes(t) == 4) a[1:0] = 2'b00;
      do_access(t, a, w, d, rlat, rdly, hcyc, bit'($urandom_range(0, 1)));
      total++;
      if (o_timeout || o_latency !== rlat + rdly + 2 || o_stall_cycles !== rlat + rdly + 2) begin
        bad++; $display("FAIL rnd_timing it=%0d latency=%0d stall=%0d want %0d", it, o_latency, o_stall_cycles, rlat + rdly + 2);
      end
      total++;
      if (o_size !== m_size(t) || o_strobe !== m_strobe(t, a) || o_wdata !== m_wdata(t, w) ||
          o_addr !== a || !o_stable) begin
        bad++; $display("FAIL rnd_req it=%0d size=%0d strobe=%b wdata=%h addr=%h want %0d/%b/%h/%h", it,
                        o_size, o_strobe, o_wdata, o_addr, m_size(t), m_strobe(t, a), m_wdata(t, w), a);
      end
      total++;
      if (o_raw !== (is_st(t) ? 32'h0 : d) || o_rd_addr !== a[1:0] || o_rd_type !== t ||
          o_adel || o_ades) begin
        bad++; $display("FAIL rnd_rd it=%0d raw=%h addr=%b type=%0d want %h/%b/%0d", it,
                        o_raw, o_rd_addr, o_rd_type, is_st(t) ? 32'h0 : d, a[1:0], t);
      end
      total++;
      if (!o_frozen || o_reissue || !o_idle_after) begin
        bad++; $display("FAIL rnd_done it=%0d frozen=%b reissue=%b idle=%b want 1/0/1", it, o_frozen, o_reissue, o_idle_after);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_min();
    test_stores();
    test_misalign();
    test_backpressure();
    test_hold();
    test_reset_midaccess();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
